// File: rtl/booth_pkg.sv
// Shared constants, operand payload and Booth digit decode for the partial-product generator.
package booth_pkg;

  localparam int unsigned OPW = 32;
  localparam int unsigned PPW = OPW + 2;
  localparam int unsigned NPP = OPW / 2 + 1;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } booth_digit_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } operand_t;

  // Radix-4 window {b[2k+1], b[2k], b[2k-1]} to signed digit; 111 folds to ZERO.
  function automatic booth_digit_t booth_decode(input logic [2:0] win);
    booth_digit_t d;
    case (win)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_sel.sv
// One Booth digit: selects 0, a or 2a and inverts for negative digits; +1 rides on neg.
module booth_sel (
  input  logic [2:0]                    win,
  input  logic [booth_pkg::OPW-1:0]     a,
  output logic [booth_pkg::PPW-1:0]     pp,
  output logic                          neg
);
  import booth_pkg::*;

  booth_digit_t digit;
  logic [OPW:0] mag;

  // Magnitude select and conditional one's complement.
  always_comb begin
    digit = booth_decode(win);
    mag   = '0;
    neg   = 1'b0;
    case (digit)
      P1: mag = {1'b0, a};
      P2: mag = {a, 1'b0};
      M1: begin
        mag = {1'b0, a};
        neg = 1'b1;
      end
      M2: begin
        mag = {a, 1'b0};
        neg = 1'b1;
      end
      default: ;
    endcase
    pp = neg ? ~{1'b0, mag} : {1'b0, mag};
  end

endmodule

// File: rtl/booth_pp_gen.sv
// Two-stage radix-4 Booth partial-product generator with valid/ready on both sides.
module booth_pp_gen #(
  parameter int unsigned OPW = 32,
  parameter int unsigned PPW = OPW + 2,
  parameter int unsigned NPP = OPW / 2 + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PPW-1:0] pp0,
  output logic [PPW-1:0] pp1,
  output logic [PPW-1:0] pp2,
  output logic [PPW-1:0] pp3,
  output logic [PPW-1:0] pp4,
  output logic [PPW-1:0] pp5,
  output logic [PPW-1:0] pp6,
  output logic [PPW-1:0] pp7,
  output logic [PPW-1:0] pp8,
  output logic [PPW-1:0] pp9,
  output logic [PPW-1:0] pp10,
  output logic [PPW-1:0] pp11,
  output logic [PPW-1:0] pp12,
  output logic [PPW-1:0] pp13,
  output logic [PPW-1:0] pp14,
  output logic [PPW-1:0] pp15,
  output logic [OPW-1:0] pp16,
  output logic [NPP-2:0] neg
);
  import booth_pkg::*;

  logic           s1_v;
  logic           s2_v;
  logic           s2_adv;
  operand_t       s1_ops;
  logic [OPW:0]   bx;
  logic [PPW-1:0] pp_sel [NPP-1];
  logic [NPP-2:0] neg_sel;
  logic [OPW-1:0] pp16_sel;
  logic [PPW-1:0] s2_pp [NPP-1];
  logic [OPW-1:0] s2_pp16;
  logic [NPP-2:0] s2_neg;

  // Handshake: stage 2 frees when empty or drained; stage 1 frees when empty or moving on.
  assign s2_adv    = !s2_v | out_ready;
  assign in_ready  = !s1_v | s2_adv;
  assign out_valid = s2_v;

  // Pipeline valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (in_ready) s1_v <= in_valid;
      if (s2_adv)   s2_v <= s1_v;
    end
  end

  // Stage 1 operand capture, only on an actual input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ops <= '0;
    end else if (in_valid && in_ready) begin
      s1_ops <= '{a: a, b: b};
    end
  end

  // b with the implicit b[-1] = 0 appended so every window is a plain slice.
  assign bx = {s1_ops.b, 1'b0};

  for (genvar k = 0; k < NPP - 1; k++) begin : g_sel
    booth_sel u_sel (
      .win (bx[2*k+2 : 2*k]),
      .a   (s1_ops.a),
      .pp  (pp_sel[k]),
      .neg (neg_sel[k])
    );
  end

  // Top digit can only be 0 or +1.
  assign pp16_sel = s1_ops.b[OPW-1] ? s1_ops.a : '0;

  // Stage 2 product capture; loads only real sets so bubbles never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NPP) - 1; k++) s2_pp[k] <= '0;
      s2_pp16 <= '0;
      s2_neg  <= '0;
    end else if (s2_adv && s1_v) begin
      for (int k = 0; k < int'(NPP) - 1; k++) s2_pp[k] <= pp_sel[k];
      s2_pp16 <= pp16_sel;
      s2_neg  <= neg_sel;
    end
  end

  assign pp0  = s2_pp[0];
  assign pp1  = s2_pp[1];
  assign pp2  = s2_pp[2];
  assign pp3  = s2_pp[3];
  assign pp4  = s2_pp[4];
  assign pp5  = s2_pp[5];
  assign pp6  = s2_pp[6];
  assign pp7  = s2_pp[7];
  assign pp8  = s2_pp[8];
  assign pp9  = s2_pp[9];
  assign pp10 = s2_pp[10];
  assign pp11 = s2_pp[11];
  assign pp12 = s2_pp[12];
  assign pp13 = s2_pp[13];
  assign pp14 = s2_pp[14];
  assign pp15 = s2_pp[15];
  assign pp16 = s2_pp16;
  assign neg  = s2_neg;

endmodule

// File: doc/booth_pp_gen.md
# booth_pp_gen

Pipelined radix-4 Booth partial-product generator for the unsigned 32x32 multiplier datapath. It accepts operand pairs over a valid/ready handshake and emits the 17 partial products plus 16 negate bits in exactly the format `PP_Compressor` consumes (`pp0..pp15` 34 bits, `pp16` 32 bits, `i[15:0]`). It sits directly upstream of the compressor. Two register stages decouple operand capture from Booth selection, and back-pressure from the compressor side is honoured without loss.

## Interface
- `OPW`, default 32: operand width. Fixed at 32; any other value is unsupported.
- `PPW`, default 34: partial-product width (`OPW+2`).
- `NPP`, default 17: partial-product count (`OPW/2+1`).
- `clk`  in  1  single clock. All state is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept a pair this cycle.
- `a`  in  32  multiplicand, unsigned.
- `b`  in  32  multiplier, unsigned.
- `out_valid`  out  1  partial-product set present.
- `out_ready`  in  1  consumer accepts the set this cycle.
- `pp0`..`pp15`  out  34 each  Booth partial products 0..15.
- `pp16`  out  32  last partial product.
- `neg`  out  16  negate bits. Connects to the compressor `i` port; `neg[k]` belongs to `ppk`.

## Operation
- Booth digit k (k=0..16) is formed from `{b[2k+1], b[2k], b[2k-1]}`, with `b[-1]=b[32]=b[33]=0`.
- Digit decode:
  - 000 and 111 give 0.
  - 001 and 010 give +1.
  - 011 gives +2.
  - 100 gives -2.
  - 101 and 110 give -1.
- Let M be the 33-bit magnitude: 0, `{1'b0,a}` or `{a,1'b0}`.
- For k<16: `ppk = neg ? ~{1'b0,M} : {1'b0,M}`, and `neg[k]` = digit negative.
  - The +1 completing the two's complement is carried by `neg[k]` at weight 2^(2k).
  - The -0 case (111) must drive `neg[k]=0` and `ppk=0`.
- Digit 16 is always 0 or +1, so `pp16 = b[31] ? a : 0`. It has no negate bit.
- Invariant: sum over k of `(sext(ppk)+neg[k])·4^k` plus `pp16·2^32` equals `a·b` mod 2^64.
- Stage 1 registers `a` and `b` with valid bit `s1_v`.
- Stage 2 registers the decoded products and negate bits with valid bit `s2_v`. `out_valid = s2_v`.
- Advance rules:
  - `s2_adv = !s2_v | out_ready`.
  - `in_ready = !s1_v | s2_adv`.
  - Stage 2 loads when `s2_adv`, and takes `s1_v` as its new valid.
  - Stage 1 loads when `in_ready`.
- A transfer occurs on a cycle when valid and ready are both high on that side.

## Timing
- Reset values:
  - `s1_v=0`, `s2_v=0`, so `out_valid=0`.
  - `in_ready=1`.
  - All `pp*` and `neg` = 0.
- Latency: a pair accepted in cycle t appears at the outputs in cycle t+2 when `out_ready` is held high.
- Throughput: one set per cycle under continuous `out_ready`.
- `in_ready` is combinational from `out_ready`. There is no combinational path from `a` or `b` to any output.
- Stall: while `out_valid & !out_ready`, the outputs hold bit-stable.
  - Stage 1 still accepts one pair if it is empty.
  - Once both stages are full, `in_ready=0`.
- Simultaneous accept and release in the full state: a pair is dropped in and one is sent out in the same cycle, with no bubble and no loss.
- Data-path registers load only on their enable. Data values in an invalid stage are don't-care, but they must not reach the outputs while `out_valid=0`.
- Reset mid-operation: both stages are cleared at once and in-flight sets are discarded. The first valid set after reset comes from a new accept.

## Structure
- Package `booth_pkg`:
  - constants `OPW`, `PPW`, `NPP`.
  - enum `booth_digit_t` with values ZERO, P1, P2, M1, M2.
  - function `booth_decode(logic [2:0])` returning `booth_digit_t`.
- Sub-module `booth_sel`:
  - Combinational, one per digit.
  - Inputs: 3-bit window and `a`.
  - Outputs: 34-bit `pp` and `neg`.
  - Instanced 16 times. The `pp16` path is a plain AND.
- The top level holds the two pipeline stages and the handshake.

## Test plan
- Reset, then `a=1`, `b=2`, `out_ready=1` -> at t+2:
  - `pp0=34'h3_FFFF_FFFD` with `neg[0]=1`.
  - `pp1=34'h1`.
  - All other products and negate bits are 0.
- `a=32'hDEADBEEF`, `b=0` -> all `pp*=0`, `neg=0`.
- `a=5`, `b=32'h8000_0000` -> `pp15=~{1'b0,33'hA}` with `neg[15]=1`, `pp16=5`, all other products 0.
- `a=b=32'hFFFF_FFFF` -> digits 1..15 are 111, so those products are 0 with `neg` 0.
  - `pp0=~{1'b0,a}` with `neg[0]=1`.
  - `pp16=a`.
  - The reconstructed sum equals `64'hFFFF_FFFE_0000_0001`.
- Random back-pressure: 10k random pairs, `in_valid` and `out_ready` each random at 50%.
  - The reconstructed product matches `a·b` for every set, in order.
  - No drops and no duplicates.
  - Outputs are stable during stalls.
- Both stages full, then assert `rst_n=0` for 1 cycle -> `out_valid=0` and `in_ready=1` immediately; the in-flight sets never appear.
